core_seq: RTL
=============

# core_seq

Multicycle sequencer for the core: a one-hot state machine that walks each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK. It drives the stage enables into core_decode, core_alu and core_reg, and owns the request/acknowledge handshake on the single shared memory port. It also detects memory timeouts and illegal instructions, and counts retired instructions.

## Interface
Parameters:
- TIMEOUT, 16, request cycles allowed without MEM_ACK before a fault; 0 disables the timeout; legal range 0..255.

Ports:
- CLK  in  1  core clock; all logic is on the rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  in IDLE, leave IDLE and begin fetching.
- HALT_REQ  in  1  return to IDLE at the next instruction boundary.
- MEM_ACK  in  1  memory completed the current request.
- IS_LOAD  in  1  decoded load; valid from DECODE until WRITEBACK.
- IS_STORE  in  1  decoded store; valid from DECODE until WRITEBACK.
- IS_ILLEGAL  in  1  decoder found no legal instruction; valid in DECODE.
- RD_WRITE  in  1  instruction writes rd; valid in WRITEBACK.
- MEM_REQ  out  1  memory request.
- MEM_SEL  out  1  address source: 0 = PC (fetch), 1 = ALU result (data).
- MEM_WE  out  1  write strobe qualifying MEM_REQ.
- IR_WE  out  1  latch MEM_DATA into the instruction register.
- DEC_EN  out  1  decode stage enable.
- EXE_EN  out  1  ALU stage enable.
- RF_WE  out  1  register-file write enable.
- PC_WE  out  1  PC write enable.
- BUSY  out  1  high when the state is not IDLE and not FAULT.
- FAULT  out  1  sticky fault flag.
- FAULT_CAUSE  out  2  fault cause: 01 = fetch timeout, 10 = data timeout, 11 = illegal instruction.
- STATE  out  7  one-hot state: IDLE = 0000001, FETCH = 0000010, DECODE = 0000100, EXECUTE = 0001000, FAULT = 0010000, MEMORY = 0100000, WRITEBACK = 1000000.
- INSTRET  out  32  count of retired instructions.

## Operation
- IDLE:
  - All strobes are low.
  - If START = 1 and HALT_REQ = 0, go to FETCH.
- FETCH:
  - MEM_REQ = 1, MEM_SEL = 0, MEM_WE = 0.
  - On MEM_ACK: IR_WE = 1 for that cycle, then go to DECODE.
- DECODE:
  - DEC_EN = 1 for one cycle.
  - If IS_ILLEGAL = 1, go to FAULT with cause 11; otherwise go to EXECUTE.
- EXECUTE:
  - EXE_EN = 1 for one cycle.
  - If IS_LOAD or IS_STORE, go to MEMORY; otherwise go to WRITEBACK.
- MEMORY:
  - MEM_REQ = 1, MEM_SEL = 1, MEM_WE = IS_STORE.
  - On MEM_ACK, go to WRITEBACK.
- WRITEBACK:
  - PC_WE = 1; RF_WE = RD_WRITE & ~IS_STORE.
  - INSTRET increments by 1; it wraps from 0xFFFFFFFF to 0.
  - Go to IDLE if a halt is pending, otherwise go to FETCH.
- FAULT:
  - Terminal. All strobes are low; FAULT = 1 and FAULT_CAUSE hold.
  - START and HALT_REQ are ignored. Only RST exits.
- Halt pending flag:
  - Set by HALT_REQ = 1 in any state except IDLE and FAULT.
  - Cleared on entry to IDLE.
- Wait counter:
  - 8 bits; cleared on entry to FETCH or MEMORY.
  - Increments on every request cycle without MEM_ACK.
  - When TIMEOUT ≠ 0 and the counter reaches TIMEOUT − 1 with MEM_ACK still low, the next state is FAULT. Cause is 01 from FETCH, 10 from MEMORY.
- MEM_ACK while MEM_REQ = 0 is ignored.
- A stuck-high MEM_ACK completes each request in its first cycle.

## Timing
- Reset: STATE = IDLE and halt flag = 0. All outputs are 0 except STATE; this includes INSTRET, FAULT and FAULT_CAUSE.
- RST has priority over every other input, including in the middle of a memory request: MEM_REQ is low in the cycle after RST is sampled.
- All outputs are Moore outputs decoded from the registered state, except these combinational terms:
  - IR_WE = FETCH & MEM_ACK.
  - MEM_WE = MEMORY & IS_STORE.
  - RF_WE = WRITEBACK & RD_WRITE & ~IS_STORE.
- Handshake:
  - MEM_REQ rises in the first cycle of FETCH or MEMORY.
  - It stays high until MEM_ACK is sampled high.
  - It drops in the cycle after the ack.
- Instruction latency with a zero-wait memory:
  - Non-memory instruction: 4 cycles (F, D, E, W).
  - Load or store: 5 cycles.
  - Each wait cycle adds 1.
- Fault timing: FAULT and FAULT_CAUSE assert in the same cycle that STATE becomes FAULT.
- MEM_ACK and the timeout condition in the same cycle: the ack wins.
- HALT_REQ sampled in the WRITEBACK cycle itself takes effect at that boundary.
- INSTRET reads updated in the cycle after WRITEBACK.

## Test plan
- ALU instruction: RST, then START; MEM_ACK in the first FETCH cycle; RD_WRITE = 1 → STATE sequence 02, 04, 08, 40; RF_WE and PC_WE high in WRITEBACK only; INSTRET = 1; next state FETCH.
- Store with 3 wait cycles: IS_STORE = 1; MEM_ACK on the 4th MEMORY cycle → MEM_SEL = 1 and MEM_WE = 1 for 4 cycles; RF_WE = 0; total latency 8 cycles.
- Timeout, TIMEOUT = 4: MEM_ACK held low in FETCH → STATE = 10 after 4 request cycles; FAULT_CAUSE = 01; START ignored afterwards; RST clears FAULT. Repeat with ack on the 4th cycle → no fault.
- Illegal instruction: IS_ILLEGAL = 1 in DECODE → FAULT with cause 11; EXE_EN never asserts; INSTRET unchanged.
- Halt: HALT_REQ pulsed during EXECUTE → current instruction retires, then STATE = IDLE and BUSY = 0; START = 1 together with HALT_REQ = 1 in IDLE → stays IDLE.
- Reset mid-MEMORY with MEM_REQ high → next cycle STATE = 01 and all outputs 0; INSTRET preset to 0xFFFFFFFF and one retire → wraps to 0.

Source files
------------

// File: rtl/core_seq_if.sv
// Bus bundle between the core sequencer and its environment: memory handshake,
// decoder status inputs, stage enables and status outputs.
interface core_seq_if;
  logic        START;
  logic        HALT_REQ;
  logic        MEM_ACK;
  logic        IS_LOAD;
  logic        IS_STORE;
  logic        IS_ILLEGAL;
  logic        RD_WRITE;
  logic        MEM_REQ;
  logic        MEM_SEL;
  logic        MEM_WE;
  logic        IR_WE;
  logic        DEC_EN;
  logic        EXE_EN;
  logic        RF_WE;
  logic        PC_WE;
  logic        BUSY;
  logic        FAULT;
  logic [1:0]  FAULT_CAUSE;
  logic [6:0]  STATE;
  logic [31:0] INSTRET;

  modport master (
    input  START, HALT_REQ, MEM_ACK, IS_LOAD, IS_STORE, IS_ILLEGAL, RD_WRITE,
    output MEM_REQ, MEM_SEL, MEM_WE, IR_WE, DEC_EN, EXE_EN, RF_WE, PC_WE,
           BUSY, FAULT, FAULT_CAUSE, STATE, INSTRET
  );

  modport slave (
    output START, HALT_REQ, MEM_ACK, IS_LOAD, IS_STORE, IS_ILLEGAL, RD_WRITE,
    input  MEM_REQ, MEM_SEL, MEM_WE, IR_WE, DEC_EN, EXE_EN, RF_WE, PC_WE,
           BUSY, FAULT, FAULT_CAUSE, STATE, INSTRET
  );
endinterface

// File: rtl/core_seq.sv
// Multicycle one-hot instruction sequencer: walks FETCH/DECODE/EXECUTE/MEMORY/
// WRITEBACK, owns the memory handshake, detects timeouts and illegal opcodes.
module core_seq #(
  parameter int TIMEOUT = 16
) (
  input  logic          CLK,
  input  logic          RST,
  core_seq_if.master    bus
);

  typedef enum logic [6:0] {
    S_IDLE      = 7'b0000001,
    S_FETCH     = 7'b0000010,
    S_DECODE    = 7'b0000100,
    S_EXECUTE   = 7'b0001000,
    S_FAULT     = 7'b0010000,
    S_MEMORY    = 7'b0100000,
    S_WRITEBACK = 7'b1000000
  } state_t;

  localparam bit         TO_EN   = (TIMEOUT != 0);
  localparam logic [7:0] TO_LAST = 8'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        halt_q, halt_d;
  logic [7:0]  wait_q, wait_d;
  logic [1:0]  cause_q, cause_d;
  logic [31:0] instret_q, instret_d;

  logic mem_req, mem_sel, mem_we, ir_we, dec_en, exe_en, rf_we, pc_we;
  logic timeout_hit;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      halt_q    <= 1'b0;
      wait_q    <= 8'd0;
      cause_q   <= 2'b00;
      instret_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      halt_q    <= halt_d;
      wait_q    <= wait_d;
      cause_q   <= cause_d;
      instret_q <= instret_d;
    end
  end

  // The ack is checked before this, so an ack in the last allowed cycle still wins.
  assign timeout_hit = TO_EN && (wait_q == TO_LAST);

  always_comb begin
    state_d   = state_q;
    halt_d    = halt_q;
    wait_d    = wait_q;
    cause_d   = cause_q;
    instret_d = instret_q;
    mem_req   = 1'b0;
    mem_sel   = 1'b0;
    mem_we    = 1'b0;
    ir_we     = 1'b0;
    dec_en    = 1'b0;
    exe_en    = 1'b0;
    rf_we     = 1'b0;
    pc_we     = 1'b0;

    if (bus.HALT_REQ && state_q != S_IDLE && state_q != S_FAULT) begin
      halt_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.START && !bus.HALT_REQ) begin
          state_d = S_FETCH;
          wait_d  = 8'd0;
        end
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (bus.MEM_ACK) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_FAULT;
          cause_d = 2'b01;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_DECODE: begin
        dec_en = 1'b1;
        if (bus.IS_ILLEGAL) begin
          state_d = S_FAULT;
          cause_d = 2'b11;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        exe_en = 1'b1;
        if (bus.IS_LOAD || bus.IS_STORE) begin
          state_d = S_MEMORY;
          wait_d  = 8'd0;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_MEMORY: begin
        mem_req = 1'b1;
        mem_sel = 1'b1;
        mem_we  = bus.IS_STORE;
        if (bus.MEM_ACK) begin
          state_d = S_WRITEBACK;
        end else if (timeout_hit) begin
          state_d = S_FAULT;
          cause_d = 2'b10;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WRITEBACK: begin
        pc_we     = 1'b1;
        rf_we     = bus.RD_WRITE & ~bus.IS_STORE;
        instret_d = instret_q + 32'd1;
        if (halt_q || bus.HALT_REQ) begin
          state_d = S_IDLE;
          halt_d  = 1'b0;
        end else begin
          state_d = S_FETCH;
          wait_d  = 8'd0;
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_IDLE;
        halt_d  = 1'b0;
      end
    endcase
  end

  assign bus.MEM_REQ     = mem_req;
  assign bus.MEM_SEL     = mem_sel;
  assign bus.MEM_WE      = mem_we;
  assign bus.IR_WE       = ir_we;
  assign bus.DEC_EN      = dec_en;
  assign bus.EXE_EN      = exe_en;
  assign bus.RF_WE       = rf_we;
  assign bus.PC_WE       = pc_we;
  assign bus.BUSY        = (state_q != S_IDLE) && (state_q != S_FAULT);
  assign bus.FAULT       = (state_q == S_FAULT);
  assign bus.FAULT_CAUSE = cause_q;
  assign bus.STATE       = state_q;
  assign bus.INSTRET     = instret_q;

endmodule
